// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with group PG/GG and signed overflow, registered output.
// Define CLA_4BIT_COMB_OUT_EN for purely combinational outputs (no registers).
module cla_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       PG,
    output logic       GG,
    output logic       Ovf,
    output logic       out_valid
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] sum_c;
    logic       pg_c;
    logic       gg_c;
    logic       ovf_c;

    assign p = A ^ B;
    assign g = A & B;

    // Flat two-level lookahead: every carry is a single sum of products.
    assign c[0] = Cin;
    assign c[1] = g[0]
                | (p[0] & Cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & Cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign sum_c = p ^ c[3:0];
    assign pg_c  = &p;
    assign gg_c  = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign ovf_c = c[4] ^ c[3];

`ifdef CLA_4BIT_COMB_OUT_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign Sum       = sum_c;
    assign Cout      = c[4];
    assign PG        = pg_c;
    assign GG        = gg_c;
    assign Ovf       = ovf_c;
    assign out_valid = in_valid;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum       <= 4'b0000;
            Cout      <= 1'b0;
            PG        <= 1'b0;
            GG        <= 1'b0;
            Ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Results hold while no new operands arrive.
            if (in_valid) begin
                Sum  <= sum_c;
                Cout <= c[4];
                PG   <= pg_c;
                GG   <= gg_c;
                Ovf  <= ovf_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cla_4bit.sv
// Scoreboard bench for cla_4bit: directed vectors, exhaustive sweep,
// hold behaviour when in_valid drops, and asynchronous reset.
module tb_cla_4bit;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       pg;
        logic       gg;
        logic       ovf;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       PG;
    logic       GG;
    logic       Ovf;
    logic       out_valid;

    int   passed;
    int   total;
    res_t q[$];
    res_t last;

    cla_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sum       (Sum),
        .Cout      (Cout),
        .PG        (PG),
        .GG        (GG),
        .Ovf       (Ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] a,
                                   input logic [3:0] b,
                                   input logic       ci);
        res_t       r;
        logic [4:0] s;
        int         sa;
        int         sb;
        int         sv;
        s      = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        sa     = $signed(a);
        sb     = $signed(b);
        sv     = sa + sb + int'(ci);
        r.sum  = s[3:0];
        r.cout = s[4];
        r.pg   = ((a ^ b) == 4'hF);
        r.gg   = (({1'b0, a} + {1'b0, b}) > 5'd15);
        r.ovf  = (sv > 7) || (sv < -8);
        return r;
    endfunction

    task automatic chk(input string tag,
                       input logic [8:0] obs,
                       input logic [8:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic check_out(input string tag);
        res_t exp_r;
        logic exp_v;
        if (q.size() != 0) begin
            exp_r = q.pop_front();
            last  = exp_r;
            exp_v = 1'b1;
        end else begin
            exp_r = last;
            exp_v = 1'b0;
        end
        chk(tag, {out_valid, Sum, Cout, PG, GG, Ovf}, {exp_v, exp_r});
    endtask

    // Check what the previous edge produced, then drive the next operands.
    task automatic step(input string tag, input logic v,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic ci);
        @(negedge clk);
        check_out(tag);
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = ci;
        if (v) q.push_back(model(a, b, ci));
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        last = '0;
        chk(tag, {out_valid, Sum, Cout, PG, GG, Ovf}, 9'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        passed   = 0;
        total    = 0;
        last     = '0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 4'($urandom_range(15));
        B        = 4'($urandom_range(15));
        Cin      = 1'($urandom_range(1));
        #2;
        chk("reset_async", {out_valid, Sum, Cout, PG, GG, Ovf}, 9'b0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_held", {out_valid, Sum, Cout, PG, GG, Ovf}, 9'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        step("idle",       1'b1, 4'b0000, 4'b0000, 1'b0);
        step("zero",       1'b1, 4'b0011, 4'b0101, 1'b0);
        step("3p5_ovf",    1'b1, 4'b1111, 4'b0001, 1'b0);
        step("f_p1_gg",    1'b1, 4'b1001, 4'b0110, 1'b1);
        step("prop_chain", 1'b1, 4'b1111, 4'b1111, 1'b1);
        step("ff_cin",     1'b0, 4'b0101, 4'b0101, 1'b1);
        step("hold1",      1'b0, 4'b1010, 4'b0011, 1'b0);
        step("hold2",      1'b1, 4'b0111, 4'b0001, 1'b0);
        step("7p1_ovf",    1'b1, 4'b1000, 4'b1000, 1'b0);
        step("m8m8_ovf",   1'b0, 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 512; i++) begin
            step("sweep", 1'b1, i[8:5], i[4:1], i[0]);
            if ((i % 64) == 63) step("sweep_gap", 1'b0, 4'hF, 4'hF, 1'b1);
        end

        ra = 4'($urandom_range(15));
        rb = 4'($urandom_range(15));
        rc = 1'($urandom_range(1));
        step("pre_rst", 1'b1, ra, rb, rc);
        reset_pulse("mid_reset");
        step("post_rst_idle", 1'b1, 4'b0110, 4'b0110, 1'b1);
        step("post_rst_first", 1'b0, 4'b0000, 4'b0000, 1'b0);
        step("post_rst_hold", 1'b0, 4'b0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cla_4bit.md
Name: cla_4bit

Overview:
- 4-bit carry-lookahead adder with a registered output stage: Sum = A + B + Cin, with carry-out, group propagate/generate and signed-overflow flags.
- Carries are computed with two-level lookahead equations, never a ripple chain.
- Serves as a leaf arithmetic cell; its group PG/GG outputs allow cascading into a second-level lookahead unit.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- A  input  4  operand A, unsigned or two's complement
- B  input  4  operand B
- Cin  input  1  carry-in
- Sum  output  4  registered sum bits
- Cout  output  1  registered carry-out (c4)
- PG  output  1  registered group propagate
- GG  output  1  registered group generate
- Ovf  output  1  registered signed overflow
- out_valid  output  1  registered result valid

Behaviour:
- Bit signals for i = 0..3: p_i = A[i] ^ B[i]; g_i = A[i] & B[i].
- Carries, written as flat sum-of-products:
  - c0 = Cin
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
- Outputs:
  - Sum[i] = p_i ^ c_i
  - Cout = c4
  - PG = p3 & p2 & p1 & p0
  - GG = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - Ovf = c4 ^ c3
- Arithmetic identity: {Cout, Sum} == A + B + Cin (5-bit result, range 0..31).
- Latency: 1 cycle.
  - On a rising clk edge with in_valid = 1: all result registers load the combinational values and out_valid <= 1.
  - With in_valid = 0: result registers hold their previous values and out_valid <= 0.
- No backpressure; a new operand set is accepted every cycle, for full throughput.
- Reset: while rst_n = 0, asynchronously force Sum = 0, Cout = 0, PG = 0, GG = 0, Ovf = 0, out_valid = 0.
  - A reset asserted mid-operation discards the in-flight result.
  - The first valid output after reset release appears one cycle after the first in_valid = 1 edge.
- X-safety: no latches; all combinational logic is fully assigned.

Optional Feature:
- Macro: CLA_4BIT_COMB_OUT_EN.
- Defined:
  - Sum, Cout, PG, GG and Ovf are driven directly from the combinational lookahead logic (0-cycle latency), independent of clk and rst_n.
  - out_valid = in_valid combinationally.
  - No registers are inferred.
- Undefined (default): the registered behaviour above.

Test Plan:
- Reset: rst_n = 0 with random inputs -> Sum = 0000, Cout = 0, out_valid = 0, asynchronously without waiting for clk.
- A = 0000, B = 0000, Cin = 0, in_valid = 1 -> next cycle: Sum = 0000, Cout = 0, PG = 0, GG = 0, Ovf = 0.
- A = 0011, B = 0101, Cin = 0 -> Sum = 1000, Cout = 0, Ovf = 1 (3+5 overflows signed 4-bit).
- A = 1111, B = 0001, Cin = 0 -> Sum = 0000, Cout = 1, GG = 1.
- A = 1001, B = 0110, Cin = 1 -> Sum = 0000, Cout = 1, PG = 1, GG = 0 (carry travels the full propagate chain).
  - A = 1111, B = 1111, Cin = 1 -> Sum = 1111, Cout = 1, Ovf = 0.
- Exhaustive sweep of all 512 (A, B, Cin) combinations against A + B + Cin.
  - in_valid deasserted between vectors -> outputs hold their last values and out_valid drops.
  - rst_n pulsed mid-stream -> outputs clear immediately.
